// File: rtl/rotator_pipe.sv
// ===========================================================================
// rotator_pipe : pipelined barrel rotator, left and right results per word
// Rev 1.0
// ===========================================================================
`default_nettype none

module rotator_pipe #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic             in_lr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_left,
   output logic [WIDTH-1:0] out_right,
   output logic             out_lr
);

   localparam int LAST = AMT_W - 1;

   logic             st_v     [AMT_W];
   logic             st_acc   [AMT_W];
   logic             st_lr    [AMT_W];
   logic [WIDTH-1:0] st_left  [AMT_W];
   logic [WIDTH-1:0] st_right [AMT_W];
   logic [AMT_W-1:0] st_amt   [AMT_W];

   for (genvar k = 0; k < AMT_W; k++) begin : g_stage
      localparam int SH = 2 ** k;

      logic             w_v_in;
      logic             w_lr_in;
      logic [WIDTH-1:0] w_left_in;
      logic [WIDTH-1:0] w_right_in;
      logic [AMT_W-1:0] w_amt_in;
      logic [WIDTH-1:0] w_left_nxt;
      logic [WIDTH-1:0] w_right_nxt;
      logic             r_v;
      logic             r_lr;
      logic [WIDTH-1:0] r_left;
      logic [WIDTH-1:0] r_right;

      if (k == 0) begin : g_head
         assign w_v_in     = in_valid;
         assign w_lr_in    = in_lr;
         assign w_left_in  = in_data;
         assign w_right_in = in_data;
         assign w_amt_in   = in_amt;
      end else begin : g_body
         assign w_v_in     = st_v[k-1];
         assign w_lr_in    = st_lr[k-1];
         assign w_left_in  = st_left[k-1];
         assign w_right_in = st_right[k-1];
         assign w_amt_in   = st_amt[k-1];
      end

      // The amount travels shifted so bit 0 is always this stage's select.
      assign w_left_nxt  = w_amt_in[0] ? ((w_left_in << SH) | (w_left_in >> (WIDTH - SH)))
                                       : w_left_in;
      assign w_right_nxt = w_amt_in[0] ? ((w_right_in >> SH) | (w_right_in << (WIDTH - SH)))
                                       : w_right_in;

      if (k == LAST) begin : g_tail
         logic unused_amt_hi;
         assign unused_amt_hi = |w_amt_in[AMT_W-1:1];
         assign st_acc[k]     = ~r_v | out_ready;
         assign st_amt[k]     = '0;
      end else begin : g_mid
         logic [AMT_W-1:0] r_amt;
         assign st_acc[k] = ~r_v | st_acc[k+1];
         assign st_amt[k] = r_amt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_amt <= '0;
            end else if (st_acc[k] && w_v_in) begin
               r_amt <= w_amt_in >> 1;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_v     <= 1'b0;
            r_lr    <= 1'b0;
            r_left  <= '0;
            r_right <= '0;
         end else begin
            if (flush) begin
               r_v <= 1'b0;
            end else if (st_acc[k]) begin
               r_v <= w_v_in;
            end
            if (st_acc[k] && w_v_in) begin
               r_lr    <= w_lr_in;
               r_left  <= w_left_nxt;
               r_right <= w_right_nxt;
            end
         end
      end

      assign st_v[k]     = r_v;
      assign st_lr[k]    = r_lr;
      assign st_left[k]  = r_left;
      assign st_right[k] = r_right;
   end

   assign in_ready  = st_acc[0] | flush;
   assign out_valid = st_v[LAST];
   assign out_left  = st_left[LAST];
   assign out_right = st_right[LAST];
   assign out_lr    = st_lr[LAST];

endmodule

`default_nettype wire

// File: tb/tb_rotator_pipe.sv
// ===========================================================================
// tb_rotator_pipe : directed self-checking bench for rotator_pipe
// Rev 1.0
// ===========================================================================
`default_nettype none

module tb_rotator_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [2:0] in_amt;
   logic       in_lr;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_left;
   logic [7:0] out_right;
   logic       out_lr;

   int n_cmp = 0;
   int n_err = 0;

   rotator_pipe #(.WIDTH(8), .AMT_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_lr     (in_lr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_left  (out_left),
      .out_right (out_right),
      .out_lr    (out_lr)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      in_amt = '0; in_lr = 1'b0; out_ready = 1'b0;
      tick; tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (out_left !== 8'h00 || out_right !== 8'h00) begin n_err++; $display("FAIL reset_data got %h/%h want 00/00", out_left, out_right); end
      n_cmp++; if (out_lr !== 1'b0) begin n_err++; $display("FAIL reset_out_lr got %b want 0", out_lr); end
      #2 rst_n = 1'b1;
      tick;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_single;
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 8'h81; in_amt = 3'd1; in_lr = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready got %b want 1", in_ready); end
      tick;
      in_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         n_cmp++;
         if (out_valid !== (c == 3)) begin n_err++; $display("FAIL single_valid cycle %0d got %b want %b", c, out_valid, (c == 3)); end
         if (c == 3) begin
            n_cmp++;
            if (out_left !== 8'h03 || out_right !== 8'hC0 || out_lr !== 1'b1)
               begin n_err++; $display("FAIL single_data got %h/%h/%b want 03/c0/1", out_left, out_right, out_lr); end
         end
         tick;
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] d  [3];
      logic [2:0] a  [3];
      logic       l  [3];
      logic [7:0] el [3];
      logic [7:0] er [3];
      d  = '{8'hB4, 8'h3C, 8'h5A};
      a  = '{3'd3, 3'd4, 3'd0};
      l  = '{1'b0, 1'b1, 1'b1};
      el = '{8'hA5, 8'hC3, 8'h5A};
      er = '{8'h96, 8'hC3, 8'h5A};
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         in_valid = (c < 3);
         if (c < 3) begin in_data = d[c]; in_amt = a[c]; in_lr = l[c]; end
         #1;
         if (c < 3) begin
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", c, in_ready); end
         end
         n_cmp++;
         if (out_valid !== (c >= 3 && c < 6)) begin n_err++; $display("FAIL b2b_valid cycle %0d got %b want %b", c, out_valid, (c >= 3 && c < 6)); end
         if (c >= 3 && c < 6) begin
            n_cmp++;
            if (out_left !== el[c-3] || out_right !== er[c-3] || out_lr !== l[c-3])
               begin n_err++; $display("FAIL b2b_data word %0d got %h/%h/%b want %h/%h/%b", c-3, out_left, out_right, out_lr, el[c-3], er[c-3], l[c-3]); end
         end
         tick;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_backpressure;
      logic [7:0] d  [5];
      logic [2:0] a  [5];
      logic       l  [5];
      logic [7:0] el [5];
      logic [7:0] er [5];
      int  ii;
      int  oi;
      logic acc_in;
      logic acc_out;
      d  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
      a  = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
      l  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      el = '{8'h02, 8'h0C, 8'h38, 8'hE1, 8'hC7};
      er = '{8'h80, 8'hC0, 8'hE0, 8'h78, 8'h7C};
      ii = 0; oi = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_valid = (ii < 5);
         if (ii < 5) begin in_data = d[ii]; in_amt = a[ii]; in_lr = l[ii]; end
         #1;
         acc_in = in_valid & in_ready;
         tick;
         if (acc_in) ii++;
      end
      n_cmp++; if (ii !== 3) begin n_err++; $display("FAIL bp_accepted got %0d want 3", ii); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      n_cmp++;
      if (out_valid !== 1'b1 || out_left !== 8'h02 || out_right !== 8'h80 || out_lr !== 1'b1)
         begin n_err++; $display("FAIL bp_frozen got %b %h/%h/%b want 1 02/80/1", out_valid, out_left, out_right, out_lr); end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && oi < 5; c++) begin
         in_valid = (ii < 5);
         if (ii < 5) begin in_data = d[ii]; in_amt = a[ii]; in_lr = l[ii]; end
         #1;
         acc_in  = in_valid & in_ready;
         acc_out = out_valid & out_ready;
         if (acc_out) begin
            n_cmp++;
            if (out_left !== el[oi] || out_right !== er[oi] || out_lr !== l[oi])
               begin n_err++; $display("FAIL bp_data word %0d got %h/%h/%b want %h/%h/%b", oi, out_left, out_right, out_lr, el[oi], er[oi], l[oi]); end
            oi++;
         end
         tick;
         if (acc_in) ii++;
      end
      in_valid = 1'b0;
      n_cmp++; if (oi !== 5 || ii !== 5) begin n_err++; $display("FAIL bp_drain got out %0d in %0d want 5 5", oi, ii); end
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_extra got %b want 0", out_valid); end
   endtask

   task automatic test_bubble;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h01; in_amt = 3'd1; in_lr = 1'b1;
      tick;
      in_valid = 1'b0;
      tick; tick;
      in_valid = 1'b1; in_data = 8'h03; in_amt = 3'd2; in_lr = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bubble_in_ready got %b want 1", in_ready); end
      tick;
      in_valid = 1'b0;
      tick; tick;
      n_cmp++;
      if (out_valid !== 1'b1 || out_left !== 8'h02 || in_ready !== 1'b1)
         begin n_err++; $display("FAIL bubble_held got %b %h rdy %b want 1 02 rdy 1", out_valid, out_left, in_ready); end
      out_ready = 1'b1;
      tick;
      n_cmp++;
      if (out_valid !== 1'b1 || out_left !== 8'h0C || out_right !== 8'hC0 || out_lr !== 1'b0)
         begin n_err++; $display("FAIL bubble_adjacent got %b %h/%h/%b want 1 0c/c0/0", out_valid, out_left, out_right, out_lr); end
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_end got %b want 0", out_valid); end
   endtask

   task automatic test_flush;
      logic seen;
      logic got;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h07; in_amt = 3'd3; in_lr = 1'b1; tick;
      in_data = 8'h0F; in_amt = 3'd5; in_lr = 1'b0; tick;
      in_data = 8'h1F; in_amt = 3'd6; in_lr = 1'b1; tick;
      flush = 1'b1; in_data = 8'hAA; in_amt = 3'd1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
      tick;
      flush = 1'b0; in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", out_valid); end
      out_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin seen = seen | out_valid; tick; end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_leak got %b want 0", seen); end
      in_valid = 1'b1; in_data = 8'h01; in_amt = 3'd7; in_lr = 1'b0;
      tick;
      in_valid = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
         if (out_valid === 1'b1) begin
            got = 1'b1;
            n_cmp++;
            if (out_left !== 8'h80 || out_right !== 8'h02 || out_lr !== 1'b0)
               begin n_err++; $display("FAIL flush_next got %h/%h/%b want 80/02/0", out_left, out_right, out_lr); end
         end
         tick;
      end
      n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL flush_next_timeout got %b want 1", got); end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h0F; in_amt = 3'd5; in_lr = 1'b1;
      tick;
      in_valid = 1'b0;
      tick; tick;
      n_cmp++;
      if (out_valid !== 1'b1 || out_left !== 8'hE1 || out_right !== 8'h78 || out_lr !== 1'b1)
         begin n_err++; $display("FAIL rstmid_pre got %b %h/%h/%b want 1 e1/78/1", out_valid, out_left, out_right, out_lr); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_left !== 8'h00 || out_right !== 8'h00 || out_lr !== 1'b0)
         begin n_err++; $display("FAIL rstmid_async got %b %h/%h/%b want 0 00/00/0", out_valid, out_left, out_right, out_lr); end
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         begin n_err++; $display("FAIL rstmid_release rdy %b valid %b want 1 0", in_ready, out_valid); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_backpressure;
      test_bubble;
      test_flush;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
